// File: rtl/pls_calc_arbiter_if.sv
// Handshake bundles around the shared-calculator arbiter: the channel request
// side (pls_req_if) and the single calculator side (pls_calc_if).
interface pls_req_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 32
);
    logic [NUM_REQ-1:0]           req_start;
    logic [NUM_REQ*DATA_SIZE-1:0] req_a;
    logic [NUM_REQ*DATA_SIZE-1:0] req_b;
    logic [NUM_REQ-1:0]           req_busy;
    logic [NUM_REQ-1:0]           req_done;
    logic [NUM_REQ*DATA_SIZE-1:0] req_result;
    logic [NUM_REQ-1:0]           req_overrun;

    modport master (
        output req_start, req_a, req_b,
        input  req_busy, req_done, req_result, req_overrun
    );
    modport slave (
        input  req_start, req_a, req_b,
        output req_busy, req_done, req_result, req_overrun
    );
endinterface

interface pls_calc_if #(
    parameter int DATA_SIZE = 32
);
    logic                 calc_start;
    logic [DATA_SIZE-1:0] calc_a;
    logic [DATA_SIZE-1:0] calc_b;
    logic                 calc_busy;
    logic [DATA_SIZE-1:0] calc_result;

    modport master (
        output calc_start, calc_a, calc_b,
        input  calc_busy, calc_result
    );
    modport slave (
        input  calc_start, calc_a, calc_b,
        output calc_busy, calc_result
    );
endinterface

// File: rtl/pls_calc_arbiter.sv
// Round-robin arbiter sharing one start/busy calculator between NUM_REQ
// pulse-generator channels; each channel keeps a private-calculator handshake.
module pls_calc_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 32
) (
    input  logic       aclk,
    input  logic       aresetn,
    pls_req_if.slave   req,
    pls_calc_if.master calc
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef logic [IDX_W-1:0]     idx_t;
    typedef logic [DATA_SIZE-1:0] data_t;
    typedef enum logic { IDLE, WAIT } state_t;

    state_t state_q, state_d;

    logic [NUM_REQ-1:0]                pending_q, pending_d;
    logic [NUM_REQ-1:0]                done_q, done_d;
    logic [NUM_REQ-1:0]                overrun_q, overrun_d;
    logic [NUM_REQ-1:0]                capture;
    logic [NUM_REQ-1:0][DATA_SIZE-1:0] result_q, result_d;
    data_t                             slot_a_q [NUM_REQ];
    data_t                             slot_b_q [NUM_REQ];

    idx_t  grant_q, grant_d;
    idx_t  last_q, last_d;
    logic  calc_start_q, calc_start_d;
    data_t calc_a_q, calc_a_d;
    data_t calc_b_q, calc_b_d;

    idx_t  sel;
    logic  sel_vld;
    logic  issue;
    logic  complete;

    function automatic idx_t wrap_idx(input int unsigned v);
        return idx_t'(v % NUM_REQ);
    endfunction

    // NOTE: every signal written in an always_comb gets a default first; a branch
    // that leaves it unassigned would otherwise infer a latch.
    // Scan from last+NUM_REQ down to last+1 so the nearest successor of last wins.
    always_comb begin
        sel     = last_q;
        sel_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (pending_q[wrap_idx(int'(last_q) + k)]) begin
                sel     = wrap_idx(int'(last_q) + k);
                sel_vld = 1'b1;
            end
        end
    end

    assign issue    = (state_q == IDLE) && sel_vld;
    assign complete = (state_q == WAIT) && !calc_start_q && !calc.calc_busy;

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // the pre-edge value of the others regardless of process order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (issue)    state_d = WAIT;
            WAIT: if (complete) state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        result_d     = result_q;
        done_d       = '0;
        capture      = '0;
        grant_d      = grant_q;
        last_d       = last_q;
        calc_start_d = 1'b0;
        calc_a_d     = calc_a_q;
        calc_b_d     = calc_b_q;

        if (issue) begin
            grant_d      = sel;
            last_d       = sel;
            calc_start_d = 1'b1;
            calc_a_d     = slot_a_q[sel];
            calc_b_d     = slot_b_q[sel];
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (complete && (grant_q == idx_t'(i))) begin
                result_d[i]  = calc.calc_result;
                done_d[i]    = 1'b1;
                pending_d[i] = 1'b0;
            end
            // A start landing on the channel's own completion edge re-arms the slot.
            if (req.req_start[i]) begin
                if (!pending_q[i] || done_d[i]) begin
                    pending_d[i] = 1'b1;
                    capture[i]   = 1'b1;
                end else begin
                    overrun_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pending_q    <= '0;
            overrun_q    <= '0;
            result_q     <= '0;
            done_q       <= '0;
            grant_q      <= '0;
            last_q       <= idx_t'(NUM_REQ - 1);
            calc_start_q <= 1'b0;
            calc_a_q     <= '0;
            calc_b_q     <= '0;
        end else begin
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            result_q     <= result_d;
            done_q       <= done_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            calc_start_q <= calc_start_d;
            calc_a_q     <= calc_a_d;
            calc_b_q     <= calc_b_d;
        end
    end

    // NOTE: operand slots are left out of reset; a slot is only read once its
    // pending bit is set, which always follows a capture.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (capture[i]) begin
                slot_a_q[i] <= req.req_a[i*DATA_SIZE +: DATA_SIZE];
                slot_b_q[i] <= req.req_b[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign req.req_busy    = pending_q;
    assign req.req_done    = done_q;
    assign req.req_result  = result_q;
    assign req.req_overrun = overrun_q;
    assign calc.calc_start = calc_start_q;
    assign calc.calc_a     = calc_a_q;
    assign calc.calc_b     = calc_b_q;

endmodule

// File: tb/tb_pls_calc_arbiter.sv
// Bench for pls_calc_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level round-robin model and calculator model.
module tb_pls_calc_arbiter;

    localparam int N = 4;
    localparam int D = 32;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    pls_req_if  #(.NUM_REQ(N), .DATA_SIZE(D)) req_if ();
    pls_calc_if #(.DATA_SIZE(D))              calc_if ();

    pls_calc_arbiter #(.NUM_REQ(N), .DATA_SIZE(D)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (req_if),
        .calc    (calc_if)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending set, operands, round-robin pointer, results.
    logic [N-1:0] m_pending, m_overrun;
    logic [D-1:0] m_a [N];
    logic [D-1:0] m_b [N];
    logic [D-1:0] m_res [N];
    logic [D-1:0] m_sum;
    int           m_last, m_inflight = -1, m_age;
    int           g_log [$];
    time          t_log [$];

    // Pre-edge snapshots of inputs, taken on the active edge.
    logic [N-1:0]   s_start = '0;
    logic [N*D-1:0] s_a, s_b;
    logic           s_rst = 1'b0;
    logic           s_cbusy = 1'b0;

    // Calculator model configuration and state.
    int           cfg_lat  = 2;
    bit           cfg_rand = 1'b0;
    int           c_cnt    = 0;
    logic [D-1:0] c_sum    = '0;

    logic [N-1:0] mon_done;
    bit           mon_issue;
    int           mon_sel;

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            if (m_pending[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic int log_at(input int i);
        if (i < g_log.size()) return g_log[i];
        return -1;
    endfunction

    function automatic time t_at(input int i);
        if (i < t_log.size()) return t_log[i];
        return 0;
    endfunction

    always @(posedge aclk) begin
        s_start <= req_if.req_start;
        s_a     <= req_if.req_a;
        s_b     <= req_if.req_b;
        s_rst   <= aresetn;
        s_cbusy <= calc_if.calc_busy;
    end

    always @(negedge aclk) begin
        if (!s_rst) begin
            m_pending  = '0;
            m_overrun  = '0;
            m_last     = N - 1;
            m_inflight = -1;
            m_age      = 0;
            for (int i = 0; i < N; i++) m_res[i] = '0;
            check("rst_calc_start", calc_if.calc_start, 1'b0);
        end else begin
            mon_issue = (m_inflight < 0) && (m_pending != '0);
            mon_done  = '0;
            if (m_inflight >= 0) begin
                m_age++;
                if (m_age >= 2 && !s_cbusy) mon_done[m_inflight] = 1'b1;
            end
            check("done", req_if.req_done, mon_done);
            if (mon_done != '0) begin
                m_res[m_inflight]     = m_sum;
                m_pending[m_inflight] = 1'b0;
                m_inflight            = -1;
            end
            check("issue", calc_if.calc_start, mon_issue);
            if (mon_issue) begin
                mon_sel = rr_pick();
                check("calc_a", calc_if.calc_a, m_a[mon_sel]);
                check("calc_b", calc_if.calc_b, m_b[mon_sel]);
                m_sum      = m_a[mon_sel] + m_b[mon_sel];
                m_last     = mon_sel;
                m_inflight = mon_sel;
                m_age      = 0;
                g_log.push_back(mon_sel);
                t_log.push_back($time);
            end
            for (int i = 0; i < N; i++) begin
                if (s_start[i]) begin
                    if (!m_pending[i]) begin
                        m_pending[i] = 1'b1;
                        m_a[i]       = s_a[i*D +: D];
                        m_b[i]       = s_b[i*D +: D];
                    end else begin
                        m_overrun[i] = 1'b1;
                    end
                end
            end
            check("busy", req_if.req_busy, m_pending);
            check("overrun", req_if.req_overrun, m_overrun);
            for (int i = 0; i < N; i++) check("result", req_if.req_result[i*D +: D], m_res[i]);
        end

        // Calculator: busy for a configurable number of cycles, junk result while busy.
        if (calc_if.calc_start === 1'b1) begin
            c_sum = calc_if.calc_a + calc_if.calc_b;
            c_cnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_lat;
            if (c_cnt == 0) begin
                calc_if.calc_busy   = 1'b0;
                calc_if.calc_result = c_sum;
            end else begin
                calc_if.calc_busy   = 1'b1;
                calc_if.calc_result = $urandom;
            end
        end else if (c_cnt > 0) begin
            c_cnt--;
            if (c_cnt == 0) begin
                calc_if.calc_busy   = 1'b0;
                calc_if.calc_result = c_sum;
            end
        end else begin
            calc_if.calc_busy   = 1'b0;
            calc_if.calc_result = c_sum;
        end
    end

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic clr();
        req_if.req_start = '0;
        for (int i = 0; i < N; i++) begin
            req_if.req_a[i*D +: D] = $urandom;
            req_if.req_b[i*D +: D] = $urandom;
        end
    endtask

    task automatic drive(input int ch, input logic [D-1:0] a, input logic [D-1:0] b);
        req_if.req_start[ch]   = 1'b1;
        req_if.req_a[ch*D +: D] = a;
        req_if.req_b[ch*D +: D] = b;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clr();
        step();
        step();
        aresetn = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (req_if.req_busy == '0 && m_inflight < 0 && !calc_if.calc_start) break;
            step();
        end
        check("idle", req_if.req_busy, '0);
    endtask

    // Re-request each masked channel on its own completion edge until the grant log reaches target.
    task automatic run_rerequest(input logic [N-1:0] mask, input int target);
        for (int cyc = 0; cyc < 400 && g_log.size() < target; cyc++) begin
            clr();
            if (m_inflight >= 0 && mask[m_inflight] && !calc_if.calc_start && !calc_if.calc_busy)
                drive(m_inflight, $urandom, $urandom);
            step();
        end
        clr();
        check("rereq_reached", g_log.size() >= target, 1'b1);
    endtask

    int base;

    initial begin
        aresetn = 1'b0;
        req_if.req_start = '0;
        req_if.req_a     = '0;
        req_if.req_b     = '0;
        repeat (3) step();
        check("reset_busy", req_if.req_busy, '0);
        check("reset_done", req_if.req_done, '0);
        check("reset_overrun", req_if.req_overrun, '0);
        check("reset_result_lo", req_if.req_result[63:0], '0);
        check("reset_result_hi", req_if.req_result[127:64], '0);
        check("reset_calc_start", calc_if.calc_start, 1'b0);
        check("reset_calc_a", calc_if.calc_a, '0);
        check("reset_calc_b", calc_if.calc_b, '0);
        aresetn = 1'b1;
        step();

        // Single request on channel 1.
        cfg_lat = 2;
        drive(1, 5, 3);
        step();
        clr();
        check("single_busy", req_if.req_busy, 4'b0010);
        check("single_no_start_yet", calc_if.calc_start, 1'b0);
        step();
        check("single_start", calc_if.calc_start, 1'b1);
        check("single_a", calc_if.calc_a, 5);
        check("single_b", calc_if.calc_b, 3);
        for (int i = 0; i < 20 && !req_if.req_done[1]; i++) step();
        check("single_done", req_if.req_done, 4'b0010);
        check("single_busy_fall", req_if.req_busy, '0);
        check("single_result", req_if.req_result[1*D +: D], 8);
        check("single_other0", req_if.req_result[0*D +: D], 0);
        check("single_other2", req_if.req_result[2*D +: D], 0);
        check("single_other3", req_if.req_result[3*D +: D], 0);

        // Contention: all four channels at once.
        do_reset();
        cfg_lat = 1;
        base = g_log.size();
        for (int c = 0; c < N; c++) drive(c, 10 * c, 1);
        step();
        clr();
        wait_idle(100);
        for (int i = 0; i < N; i++) check("cont_order", log_at(base + i), i);
        check("cont_res0", req_if.req_result[0*D +: D], 1);
        check("cont_res1", req_if.req_result[1*D +: D], 11);
        check("cont_res2", req_if.req_result[2*D +: D], 21);
        check("cont_res3", req_if.req_result[3*D +: D], 31);
        base = g_log.size();
        drive(0, 100, 1);
        drive(2, 200, 2);
        step();
        clr();
        wait_idle(100);
        check("pair_first", log_at(base), 0);
        check("pair_second", log_at(base + 1), 2);

        // Fairness: 0 and 3 re-request on their completion edges.
        base = g_log.size();
        drive(0, $urandom, $urandom);
        step();
        clr();
        drive(3, $urandom, $urandom);
        step();
        clr();
        run_rerequest(4'b1001, base + 6);
        wait_idle(100);
        for (int i = 0; i < 6; i++) check("fair_order", log_at(base + i), (i % 2 == 0) ? 0 : 3);
        check("fair_no_overrun", req_if.req_overrun, '0);

        // Overrun on channel 2.
        cfg_lat = 3;
        base = g_log.size();
        drive(2, 4, 4);
        step();
        clr();
        drive(2, 7, 9);
        step();
        clr();
        wait_idle(100);
        check("ovr_result", req_if.req_result[2*D +: D], 8);
        check("ovr_flag", req_if.req_overrun, 4'b0100);
        check("ovr_single_op", g_log.size() - base, 1);
        repeat (5) step();
        check("ovr_sticky", req_if.req_overrun, 4'b0100);

        // Zero-latency calculator, three channels streaming.
        cfg_lat = 0;
        base = g_log.size();
        for (int c = 0; c < 3; c++) drive(c, $urandom, $urandom);
        step();
        clr();
        run_rerequest(4'b0111, base + 9);
        wait_idle(100);
        for (int i = 0; i < 9; i++) check("zl_order", log_at(base + i), i % 3);
        for (int i = 1; i < 9; i++) check("zl_cadence", t_at(base + i) - t_at(base + i - 1), 30);
        check("zl_overrun", req_if.req_overrun, 4'b0100);

        // Random traffic, random calculator latency.
        cfg_rand = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            clr();
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) drive(c, $urandom, $urandom);
            end
            step();
        end
        clr();
        wait_idle(200);

        // Reset while waiting on the calculator with two channels pending.
        cfg_rand = 1'b0;
        cfg_lat  = 6;
        drive(1, $urandom, $urandom);
        drive(3, $urandom, $urandom);
        step();
        clr();
        for (int i = 0; i < 10 && !calc_if.calc_start; i++) step();
        check("mid_granted", calc_if.calc_start, 1'b1);
        step();
        check("mid_pending", req_if.req_busy, 4'b1010);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        check("mid_rst_busy", req_if.req_busy, '0);
        check("mid_rst_done", req_if.req_done, '0);
        check("mid_rst_overrun", req_if.req_overrun, '0);
        check("mid_rst_result_lo", req_if.req_result[63:0], '0);
        check("mid_rst_result_hi", req_if.req_result[127:64], '0);
        check("mid_rst_calc_start", calc_if.calc_start, 1'b0);
        base = g_log.size();
        drive(3, 33, 44);
        drive(0, 11, 22);
        step();
        clr();
        step();
        check("post_rst_start", calc_if.calc_start, 1'b1);
        check("post_rst_a", calc_if.calc_a, 11);
        check("post_rst_grant", log_at(base), 0);
        wait_idle(100);
        check("post_rst_res0", req_if.req_result[0*D +: D], 33);
        check("post_rst_res3", req_if.req_result[3*D +: D], 77);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
